// File: rtl/cpu_core.sv
// Multi-cycle 16-bit load/store core: fetch, execute, optional memory cycle, halt.
// r0 reads as zero; r1..r15 hold their contents through reset.

module cpu_core_reg_file #(
    parameter int DATA_WIDTH = 16
) (
    input  logic                  clk,
    input  logic                  write_enable,
    input  logic [3:0]            write_addr,
    input  logic [DATA_WIDTH-1:0] write_data,
    input  logic [3:0]            read_addr_b,
    input  logic [3:0]            read_addr_c,
    output logic [DATA_WIDTH-1:0] read_data_b,
    output logic [DATA_WIDTH-1:0] read_data_c
);
    logic [DATA_WIDTH-1:0] regs [0:15];

    always_ff @(posedge clk) begin
        if (write_enable && (write_addr != 4'd0)) begin
            regs[write_addr] <= write_data;
        end
    end

    assign read_data_b = (read_addr_b == 4'd0) ? '0 : regs[read_addr_b];
    assign read_data_c = (read_addr_c == 4'd0) ? '0 : regs[read_addr_c];
endmodule

// state | meaning
// FETCH | instr_mem_addr=pc, instruction words arrive next cycle
// EXEC  | decode and execute; stalls here on an unready accelerator
// MEM   | load data returns, load retires
// HALT  | frozen until reset
module cpu_core #(
    parameter int DATA_WIDTH       = 16,
    parameter int INSTR_WIDTH      = 16,
    parameter int INSTR_ADDR_WIDTH = 10,
    parameter int DATA_ADDR_WIDTH  = 10,
    parameter int ACCEL_ID_WIDTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [INSTR_ADDR_WIDTH-1:0] instr_mem_addr,
    input  logic [INSTR_WIDTH-1:0]      instr_mem_data_0,
    input  logic [INSTR_WIDTH-1:0]      instr_mem_data_1,
    output logic [DATA_ADDR_WIDTH-1:0]  data_mem_addr,
    input  logic [DATA_WIDTH-1:0]       data_mem_read_data,
    output logic                        data_mem_write_enable,
    output logic [DATA_WIDTH-1:0]       data_mem_write_data,
    output logic [ACCEL_ID_WIDTH-1:0]   accel_id,
    input  logic                        accel_can_read,
    input  logic                        accel_can_write,
    output logic                        accel_read_enable,
    input  logic [DATA_WIDTH-1:0]       accel_read_data,
    output logic                        accel_write_enable,
    output logic [DATA_WIDTH-1:0]       accel_write_data
);
    typedef enum logic [1:0] {
        S_FETCH,
        S_EXEC,
        S_MEM,
        S_HALT
    } state_t;

    localparam logic [INSTR_ADDR_WIDTH-1:0] PC_ONE = INSTR_ADDR_WIDTH'(1);
    localparam logic [INSTR_ADDR_WIDTH-1:0] PC_TWO = INSTR_ADDR_WIDTH'(2);

    state_t                      state;
    state_t                      state_next;
    logic [INSTR_ADDR_WIDTH-1:0] pc;
    logic [INSTR_ADDR_WIDTH-1:0] pc_next;
    logic [31:0]                 executed;
    logic                        retire;

    logic [3:0]            op;
    logic [3:0]            fa;
    logic [3:0]            fb;
    logic [3:0]            fc;
    logic [DATA_WIDTH-1:0] rd_b;
    logic [DATA_WIDTH-1:0] rd_c;
    logic [DATA_WIDTH-1:0] alu_res;
    logic                  rf_we;
    logic [DATA_WIDTH-1:0] rf_wd;

    // pc is stable through EXEC and MEM, so the instruction words stay valid
    // without a local instruction register.
    assign op = instr_mem_data_0[15:12];
    assign fa = instr_mem_data_0[11:8];
    assign fb = instr_mem_data_0[7:4];
    assign fc = instr_mem_data_0[3:0];

    assign instr_mem_addr = pc;

    cpu_core_reg_file #(
        .DATA_WIDTH(DATA_WIDTH)
    ) cpu_reg_file (
        .clk         (clk),
        .write_enable(rf_we),
        .write_addr  (fa),
        .write_data  (rf_wd),
        .read_addr_b (fb),
        .read_addr_c (fc),
        .read_data_b (rd_b),
        .read_data_c (rd_c)
    );

    always_comb begin
        alu_res = '0;
        case (op[2:0])
            3'd0: alu_res = rd_b + rd_c;
            3'd1: alu_res = rd_b - rd_c;
            3'd2: alu_res = rd_b & rd_c;
            3'd3: alu_res = rd_b | rd_c;
            3'd4: alu_res = rd_b ^ rd_c;
            3'd5: alu_res = rd_b << rd_c[3:0];
            3'd6: alu_res = rd_b >> rd_c[3:0];
            3'd7: alu_res = (rd_b < rd_c) ? DATA_WIDTH'(1) : '0;
            default: alu_res = '0;
        endcase
    end

    always_comb begin
        state_next            = state;
        pc_next               = pc + PC_ONE;
        retire                = 1'b0;
        rf_we                 = 1'b0;
        rf_wd                 = alu_res;
        data_mem_addr         = rd_b[DATA_ADDR_WIDTH-1:0];
        data_mem_write_enable = 1'b0;
        data_mem_write_data   = rd_c;
        accel_id              = '0;
        accel_read_enable     = 1'b0;
        accel_write_enable    = 1'b0;
        accel_write_data      = rd_b;

        case (state)
            S_FETCH: state_next = S_EXEC;
            S_EXEC: begin
                case (op)
                    4'h8: begin
                        rf_wd   = instr_mem_data_1;
                        rf_we   = 1'b1;
                        pc_next = pc + PC_TWO;
                        retire  = 1'b1;
                    end
                    4'h9: state_next = S_MEM;
                    4'hA: begin
                        data_mem_write_enable = 1'b1;
                        retire                = 1'b1;
                    end
                    4'hB: begin
                        pc_next = (rd_b != '0) ? instr_mem_data_1[INSTR_ADDR_WIDTH-1:0]
                                               : pc + PC_TWO;
                        retire  = 1'b1;
                    end
                    4'hC: begin
                        pc_next = rd_b[INSTR_ADDR_WIDTH-1:0];
                        retire  = 1'b1;
                    end
                    4'hD: begin
                        accel_id = ACCEL_ID_WIDTH'(fc);
                        if (accel_can_read) begin
                            accel_read_enable = 1'b1;
                            rf_wd             = accel_read_data;
                            rf_we             = 1'b1;
                            retire            = 1'b1;
                        end
                    end
                    4'hE: begin
                        accel_id = ACCEL_ID_WIDTH'(fc);
                        if (accel_can_write) begin
                            accel_write_enable = 1'b1;
                            retire             = 1'b1;
                        end
                    end
                    4'hF: state_next = S_HALT;
                    default: begin
                        rf_we  = 1'b1;
                        retire = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                rf_wd  = data_mem_read_data;
                rf_we  = 1'b1;
                retire = 1'b1;
            end
            S_HALT: state_next = S_HALT;
            default: state_next = S_FETCH;
        endcase

        if (retire) begin
            state_next = S_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            pc       <= '0;
            executed <= '0;
        end else begin
            state <= state_next;
            if (retire) begin
                pc       <= pc_next;
                executed <= executed + 32'd1;
            end
        end
    end
endmodule

// File: tb/tb_cpu_core.sv
// Bench for cpu_core: ALU vector table, directed multi-cycle sequences, and a
// random program checked against an instruction-level reference model.
module tb_cpu_core;
    localparam int DW = 16;
    localparam int IAW = 10;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic [IAW-1:0]  instr_mem_addr;
    logic [15:0]     instr_mem_data_0;
    logic [15:0]     instr_mem_data_1;
    logic [9:0]      data_mem_addr;
    logic [DW-1:0]   data_mem_read_data;
    logic            data_mem_write_enable;
    logic [DW-1:0]   data_mem_write_data;
    logic [3:0]      accel_id;
    logic            accel_can_read = 1'b1;
    logic            accel_can_write = 1'b1;
    logic            accel_read_enable;
    logic [DW-1:0]   acc_data = 16'h0;
    logic            accel_write_enable;
    logic [DW-1:0]   accel_write_data;

    always #5 clk = ~clk;

    cpu_core dut (
        .clk                  (clk),
        .rst                  (rst),
        .instr_mem_addr       (instr_mem_addr),
        .instr_mem_data_0     (instr_mem_data_0),
        .instr_mem_data_1     (instr_mem_data_1),
        .data_mem_addr        (data_mem_addr),
        .data_mem_read_data   (data_mem_read_data),
        .data_mem_write_enable(data_mem_write_enable),
        .data_mem_write_data  (data_mem_write_data),
        .accel_id             (accel_id),
        .accel_can_read       (accel_can_read),
        .accel_can_write      (accel_can_write),
        .accel_read_enable    (accel_read_enable),
        .accel_read_data      (acc_data),
        .accel_write_enable   (accel_write_enable),
        .accel_write_data     (accel_write_data)
    );

    logic [15:0] imem [0:1023];
    logic [15:0] dmem [0:1023];
    logic        dm_load = 1'b0;
    int          rd_pops = 0;
    int          push_cnt = 0;
    logic [15:0] push_data = 16'h0;
    logic [3:0]  push_id = 4'h0;

    always @(posedge clk) begin
        instr_mem_data_0 <= imem[instr_mem_addr];
        instr_mem_data_1 <= imem[instr_mem_addr + 10'd1];
        data_mem_read_data <= dmem[data_mem_addr];
        if (dm_load) begin
            for (int i = 0; i < 1024; i++) dmem[i] <= 16'(i * 37 + 5);
        end else if (data_mem_write_enable) begin
            dmem[data_mem_addr] <= data_mem_write_data;
        end
        if (accel_read_enable) rd_pops <= rd_pops + 1;
        if (accel_write_enable) begin
            push_cnt  <= push_cnt + 1;
            push_data <= accel_write_data;
            push_id   <= accel_id;
        end
    end

    int n_checks = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_imem();
        for (int i = 0; i < 1024; i++) imem[i] = 16'h0000;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        dm_load = 1'b1;
        @(negedge clk);
        dm_load = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] rreg(input int r);
        return 32'(dut.cpu_reg_file.regs[r]);
    endfunction

    typedef struct {
        logic [3:0]  op;
        logic [15:0] b;
        logic [15:0] c;
        logic [15:0] exp;
    } alu_vec_t;

    alu_vec_t vecs [12];

    logic [15:0] m_r [16];
    bit          m_v [16];
    logic [15:0] m_dm [1024];
    logic [9:0]  m_pc;
    int          m_exec;
    logic [15:0] w0, w1, vb, vc, res, exp_push;
    logic [3:0]  op, fa, fb, fc;
    bit          wr, rv, push;
    int          lat, p0, pops0, dm_bad;
    logic [9:0]  npc;

    initial begin
        vecs[0]  = '{4'h0, 16'h0005, 16'h0007, 16'h000C};
        vecs[1]  = '{4'h0, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[2]  = '{4'h1, 16'h0000, 16'h0001, 16'hFFFF};
        vecs[3]  = '{4'h1, 16'h1234, 16'h0234, 16'h1000};
        vecs[4]  = '{4'h2, 16'hF0F0, 16'hFF00, 16'hF000};
        vecs[5]  = '{4'h3, 16'hF0F0, 16'h0F00, 16'hFFF0};
        vecs[6]  = '{4'h4, 16'hFFFF, 16'h0F0F, 16'hF0F0};
        vecs[7]  = '{4'h5, 16'h0001, 16'h0013, 16'h0008};
        vecs[8]  = '{4'h6, 16'h8000, 16'h00FF, 16'h0001};
        vecs[9]  = '{4'h7, 16'h0001, 16'h0002, 16'h0001};
        vecs[10] = '{4'h7, 16'hFFFF, 16'h0001, 16'h0000};
        vecs[11] = '{4'h7, 16'h0005, 16'h0005, 16'h0000};

        // All-zero memory: ADD r0,r0,r0 forever
        clear_imem();
        do_reset();
        chk("reset_pc", 32'(dut.pc), 32'd0);
        chk("reset_executed", dut.executed, 32'd0);
        chk("reset_strobes", {29'd0, data_mem_write_enable, accel_read_enable, accel_write_enable}, 32'd0);
        chk("reset_accel_id", 32'(accel_id), 32'd0);
        run_cycles(10);
        chk("zero_pc", 32'(dut.pc), 32'd5);
        chk("zero_executed", dut.executed, 32'd5);

        // ALU table: LI r1,b; LI r2,c; OP r3,r1,r2
        for (int v = 0; v < 12; v++) begin
            clear_imem();
            imem[0] = 16'h8100; imem[1] = vecs[v].b;
            imem[2] = 16'h8200; imem[3] = vecs[v].c;
            imem[4] = {vecs[v].op, 12'h312};
            imem[5] = 16'hF000;
            do_reset();
            run_cycles(6);
            chk($sformatf("alu_vec%0d_r3", v), rreg(3), 32'(vecs[v].exp));
            chk($sformatf("alu_vec%0d_pc", v), 32'(dut.pc), 32'd5);
            chk($sformatf("alu_vec%0d_exec", v), dut.executed, 32'd3);
        end

        // Store then load
        clear_imem();
        imem[0] = 16'h8100; imem[1] = 16'h0003;
        imem[2] = 16'h8200; imem[3] = 16'hBEEF;
        imem[4] = 16'hA012; imem[5] = 16'h9510; imem[6] = 16'hF000;
        do_reset();
        run_cycles(5);
        chk("st_we", 32'(data_mem_write_enable), 32'd1);
        chk("st_addr", 32'(data_mem_addr), 32'd3);
        chk("st_wdata", 32'(data_mem_write_data), 32'hBEEF);
        run_cycles(1);
        chk("st_mem", 32'(dmem[3]), 32'hBEEF);
        chk("st_we_drop", 32'(data_mem_write_enable), 32'd0);
        run_cycles(2);
        chk("ld_not_yet", dut.executed, 32'd3);
        run_cycles(1);
        chk("ld_exec", dut.executed, 32'd4);
        chk("ld_r5", rreg(5), 32'hBEEF);
        chk("ld_pc", 32'(dut.pc), 32'd6);

        // Countdown loop then HALT
        clear_imem();
        imem[0] = 16'h8100; imem[1] = 16'h0003;
        imem[2] = 16'h8200; imem[3] = 16'h0001;
        imem[4] = 16'h1112; imem[5] = 16'hB010; imem[6] = 16'h0004;
        imem[7] = 16'hF000;
        do_reset();
        run_cycles(8);
        chk("loop_taken_pc", 32'(dut.pc), 32'd4);
        chk("loop_taken_r1", rreg(1), 32'd2);
        run_cycles(8);
        chk("loop_exit_r1", rreg(1), 32'd0);
        chk("loop_exit_pc", 32'(dut.pc), 32'd7);
        chk("loop_exit_exec", dut.executed, 32'd8);
        run_cycles(10);
        chk("halt_pc", 32'(dut.pc), 32'd7);
        chk("halt_exec", dut.executed, 32'd8);

        // Accelerator read/write with stalls
        clear_imem();
        imem[0] = 16'hD602; imem[1] = 16'hE065; imem[2] = 16'hF000;
        accel_can_read = 1'b0;
        accel_can_write = 1'b0;
        do_reset();
        run_cycles(6);
        chk("ard_stall_exec", dut.executed, 32'd0);
        chk("ard_stall_pc", 32'(dut.pc), 32'd0);
        chk("ard_stall_id", 32'(accel_id), 32'd2);
        chk("ard_stall_re", 32'(accel_read_enable), 32'd0);
        @(negedge clk);
        pops0 = rd_pops;
        acc_data = 16'd42;
        accel_can_read = 1'b1;
        #1;
        chk("ard_re", 32'(accel_read_enable), 32'd1);
        run_cycles(1);
        chk("ard_exec", dut.executed, 32'd1);
        chk("ard_r6", rreg(6), 32'd42);
        chk("ard_re_drop", 32'(accel_read_enable), 32'd0);
        chk("ard_pops", 32'(rd_pops - pops0), 32'd1);
        run_cycles(4);
        chk("awr_stall_exec", dut.executed, 32'd1);
        chk("awr_stall_id", 32'(accel_id), 32'd5);
        chk("awr_stall_we", 32'(accel_write_enable), 32'd0);
        @(negedge clk);
        p0 = push_cnt;
        accel_can_write = 1'b1;
        run_cycles(1);
        chk("awr_exec", dut.executed, 32'd2);
        chk("awr_count", 32'(push_cnt - p0), 32'd1);
        chk("awr_data", 32'(push_data), 32'd42);
        chk("awr_id", 32'(push_id), 32'd5);

        // Two-word instruction at the last address wraps to address 0
        clear_imem();
        imem[0] = 16'h8100; imem[1] = 16'h03FF; imem[2] = 16'hC010;
        imem[1023] = 16'h8700;
        do_reset();
        run_cycles(6);
        chk("wrap_r7", rreg(7), 32'h8100);
        chk("wrap_pc", 32'(dut.pc), 32'd1);
        chk("wrap_exec", dut.executed, 32'd3);

        // Reset while a load sits in its memory cycle
        clear_imem();
        imem[0] = 16'h8500; imem[1] = 16'h5555;
        imem[2] = 16'h8100; imem[3] = 16'h0003;
        imem[4] = 16'h9510; imem[5] = 16'hF000;
        do_reset();
        run_cycles(6);
        chk("rstld_pre_exec", dut.executed, 32'd2);
        rst = 1'b1;
        #1;
        chk("rstld_pc", 32'(dut.pc), 32'd0);
        chk("rstld_exec", dut.executed, 32'd0);
        chk("rstld_we", 32'(data_mem_write_enable), 32'd0);
        run_cycles(1);
        chk("rstld_r5", rreg(5), 32'h5555);
        chk("rstld_r1", rreg(1), 32'd3);

        // Random program against the instruction-level model
        clear_imem();
        for (int i = 1; i < 16; i++) begin
            imem[2 * i - 2] = {4'h8, 4'(i), 8'h00};
            imem[2 * i - 1] = 16'($urandom);
        end
        for (int i = 30; i < 1024; i++) begin
            w0 = 16'($urandom);
            if (w0[15:12] == 4'hF) w0[15:12] = 4'h0;
            imem[i] = w0;
        end
        for (int i = 0; i < 16; i++) begin
            m_r[i] = 16'h0;
            m_v[i] = (i == 0);
        end
        for (int i = 0; i < 1024; i++) m_dm[i] = 16'(i * 37 + 5);
        m_pc = 10'd0;
        m_exec = 0;
        accel_can_read = 1'b1;
        accel_can_write = 1'b1;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            acc_data = 16'($urandom);
            w0 = imem[m_pc];
            w1 = imem[m_pc + 10'd1];
            op = w0[15:12]; fa = w0[11:8]; fb = w0[7:4]; fc = w0[3:0];
            vb = m_r[fb]; vc = m_r[fc];
            lat = 2; wr = 1'b0; rv = 1'b0; push = 1'b0; res = 16'h0;
            npc = m_pc + 10'd1;
            case (op)
                4'h0: begin res = vb + vc; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h1: begin res = vb - vc; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h2: begin res = vb & vc; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h3: begin res = vb | vc; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h4: begin res = vb ^ vc; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h5: begin res = vb << vc[3:0]; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h6: begin res = vb >> vc[3:0]; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h7: begin res = (vb < vc) ? 16'd1 : 16'd0; wr = 1'b1; rv = m_v[fb] && m_v[fc]; end
                4'h8: begin res = w1; wr = 1'b1; rv = 1'b1; npc = m_pc + 10'd2; end
                4'h9: begin res = m_dm[vb[9:0]]; wr = 1'b1; rv = m_v[fb]; lat = 3; end
                4'hA: m_dm[vb[9:0]] = vc;
                4'hB: npc = (vb != 16'h0) ? w1[9:0] : m_pc + 10'd2;
                4'hC: npc = vb[9:0];
                4'hD: begin res = acc_data; wr = 1'b1; rv = 1'b1; end
                4'hE: begin push = 1'b1; exp_push = vb; end
                default: ;
            endcase
            if (wr && fa != 4'd0) begin
                m_r[fa] = res;
                m_v[fa] = rv;
            end
            m_pc = npc;
            m_exec++;
            p0 = push_cnt;
            run_cycles(lat);
            chk($sformatf("rnd%0d_pc", n), 32'(dut.pc), 32'(m_pc));
            chk($sformatf("rnd%0d_exec", n), dut.executed, 32'(m_exec));
            for (int r = 1; r < 16; r++) begin
                if (m_v[r]) chk($sformatf("rnd%0d_r%0d", n, r), rreg(r), 32'(m_r[r]));
            end
            chk($sformatf("rnd%0d_pushes", n), 32'(push_cnt - p0), push ? 32'd1 : 32'd0);
            if (push) begin
                chk($sformatf("rnd%0d_push_data", n), 32'(push_data), 32'(exp_push));
                chk($sformatf("rnd%0d_push_id", n), 32'(push_id), 32'(fc));
            end
        end
        dm_bad = 0;
        for (int i = 0; i < 1024; i++) begin
            if (dmem[i] !== m_dm[i]) dm_bad++;
        end
        chk("rnd_dmem_words_differing", 32'(dm_bad), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
